// File: rtl/pixel_tx_feeder.sv
// Camera-to-UART word feeder: frames pixel words behind a header marker and queues them
// in a first-word-fall-through FIFO, dropping (and counting) words that arrive while full.
module pixel_tx_feeder #(
  parameter int          DEPTH  = 16,
  parameter logic [15:0] HEADER = 16'hA55A
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        frame_start,
  input  logic [15:0] pix_data,
  input  logic        pix_valid,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  input  logic        clr_ovf,
  output logic        overflow,
  output logic [15:0] drop_cnt,
  output logic [7:0]  frame_cnt
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    WAIT_FRAME,
    STREAM,
    DROP
  } state_t;

  state_t         state_reg, state_next;
  logic [15:0]    mem [DEPTH];
  logic [AW-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]    count_reg;
  logic           overflow_reg;
  logic [15:0]    drop_cnt_reg;
  logic [7:0]     frame_cnt_reg;

  logic           full, empty;
  logic           push, pop, drop, frame_inc;
  logic [15:0]    push_data;

  assign full      = (count_reg == FULL_CNT);
  assign empty     = (count_reg == '0);
  assign out_valid = !empty;
  assign out_data  = mem[rd_ptr_reg];
  assign pop       = out_valid && out_ready;
  assign overflow  = overflow_reg;
  assign drop_cnt  = drop_cnt_reg;
  assign frame_cnt = frame_cnt_reg;

  // frame_start takes priority over any pixel in the same cycle; that pixel is discarded silently.
  always_comb begin
    state_next = state_reg;
    push       = 1'b0;
    push_data  = pix_data;
    drop       = 1'b0;
    frame_inc  = 1'b0;
    if (frame_start) begin
      if (!full) begin
        push       = 1'b1;
        push_data  = HEADER;
        frame_inc  = 1'b1;
        state_next = STREAM;
      end else begin
        drop       = 1'b1;
        state_next = WAIT_FRAME;
      end
    end else begin
      case (state_reg)
        WAIT_FRAME: state_next = WAIT_FRAME;
        STREAM: begin
          if (pix_valid) begin
            if (!full) begin
              push = 1'b1;
            end else begin
              drop       = 1'b1;
              state_next = DROP;
            end
          end
        end
        DROP: begin
          if (pix_valid) drop = 1'b1;
        end
        default: state_next = WAIT_FRAME;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= WAIT_FRAME;
    end else begin
      state_reg <= state_next;
    end
  end

  // Storage carries no reset; stale contents are never visible because out_valid follows count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      if (push && !pop) begin
        count_reg <= count_reg + (AW + 1)'(1);
      end else if (pop && !push) begin
        count_reg <= count_reg - (AW + 1)'(1);
      end
    end
  end

  // A drop coinciding with clr_ovf restarts the tally at one rather than zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow_reg  <= 1'b0;
      drop_cnt_reg  <= '0;
      frame_cnt_reg <= '0;
    end else begin
      if (drop) begin
        overflow_reg <= 1'b1;
        if (clr_ovf) begin
          drop_cnt_reg <= 16'd1;
        end else if (drop_cnt_reg != 16'hFFFF) begin
          drop_cnt_reg <= drop_cnt_reg + 16'd1;
        end
      end else if (clr_ovf) begin
        overflow_reg <= 1'b0;
        drop_cnt_reg <= '0;
      end
      if (frame_inc) frame_cnt_reg <= frame_cnt_reg + 8'd1;
    end
  end

endmodule

// File: tb/tb_pixel_tx_feeder.sv
// Directed bench for pixel_tx_feeder: a vector table for the basic framing path plus
// hand sequences for fill/overflow, DROP-state behaviour, saturation, reset and stall handling.
module tb_pixel_tx_feeder;

  logic        clk;
  logic        reset_n;
  logic        frame_start;
  logic [15:0] pix_data;
  logic        pix_valid;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        clr_ovf;
  logic        overflow;
  logic [15:0] drop_cnt;
  logic [7:0]  frame_cnt;

  int errors;
  int checks;

  pixel_tx_feeder #(.DEPTH(16), .HEADER(16'hA55A)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .frame_start (frame_start),
    .pix_data    (pix_data),
    .pix_valid   (pix_valid),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .clr_ovf     (clr_ovf),
    .overflow    (overflow),
    .drop_cnt    (drop_cnt),
    .frame_cnt   (frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        fs;
    logic        pv;
    logic [15:0] pd;
    logic        rdy;
    logic        clr;
    logic        ev;
    logic [15:0] ed;
    logic        eovf;
    logic [15:0] edc;
    logic [7:0]  efc;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic fs, input logic pv, input logic [15:0] pd,
                       input logic rdy, input logic clr);
    frame_start = fs;
    pix_valid   = pv;
    pix_data    = pd;
    out_ready   = rdy;
    clr_ovf     = clr;
  endtask

  task automatic do_reset;
    reset_n = 1'b0;
    drive(0, 0, 16'h0, 0, 0);
    tick;
    tick;
    reset_n = 1'b1;
  endtask

  initial begin
    logic [15:0] exp_q[$];
    logic [15:0] exp_w;
    logic [15:0] hold_d;
    logic        hold;
    int          sent;
    int          popped;
    int          cyc;

    errors  = 0;
    checks  = 0;
    clk     = 1'b0;
    reset_n = 1'b0;
    drive(0, 0, 16'h0, 0, 0);
    tick;
    tick;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_overflow", overflow, 0);
    chk("reset_drop_cnt", drop_cnt, 0);
    chk("reset_frame_cnt", frame_cnt, 0);
    reset_n = 1'b1;

    // fs pv pd rdy clr | ev ed eovf edc efc
    vecs[0] = '{1'b0, 1'b1, 16'h1234, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'd0, 8'd0};
    vecs[1] = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'hA55A, 1'b0, 16'd0, 8'd1};
    vecs[2] = '{1'b0, 1'b1, 16'h0001, 1'b1, 1'b0, 1'b1, 16'h0001, 1'b0, 16'd0, 8'd1};
    vecs[3] = '{1'b0, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b1, 16'h0002, 1'b0, 16'd0, 8'd1};
    vecs[4] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'd0, 8'd1};
    vecs[5] = '{1'b1, 1'b1, 16'h7777, 1'b0, 1'b0, 1'b1, 16'hA55A, 1'b0, 16'd0, 8'd2};
    vecs[6] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'hA55A, 1'b0, 16'd0, 8'd2};
    vecs[7] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'd0, 8'd2};

    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].fs, vecs[i].pv, vecs[i].pd, vecs[i].rdy, vecs[i].clr);
      tick;
      chk($sformatf("vec%0d_out_valid", i), out_valid, vecs[i].ev);
      if (vecs[i].ev) chk($sformatf("vec%0d_out_data", i), out_data, vecs[i].ed);
      chk($sformatf("vec%0d_overflow", i), overflow, vecs[i].eovf);
      chk($sformatf("vec%0d_drop_cnt", i), drop_cnt, vecs[i].edc);
      chk($sformatf("vec%0d_frame_cnt", i), frame_cnt, vecs[i].efc);
      $display("vec %0d: fs=%0d pv=%0d pd=%h rdy=%0d -> valid=%0d data=%h dc=%0d fc=%0d",
               i, vecs[i].fs, vecs[i].pv, vecs[i].pd, vecs[i].rdy,
               out_valid, out_data, drop_cnt, frame_cnt);
    end

    // Fill with out_ready low: header + 15 pixels fit, 5 pixels drop.
    drive(1, 0, 16'h0, 0, 0);
    tick;
    for (int i = 0; i < 20; i++) begin
      drive(0, 1, 16'(i + 1), 0, 0);
      tick;
    end
    chk("fill_overflow", overflow, 1);
    chk("fill_drop_cnt", drop_cnt, 5);
    chk("fill_frame_cnt", frame_cnt, 3);
    chk("fill_head", out_data, 16'hA55A);
    drive(1, 0, 16'h0, 0, 0);
    tick;
    chk("full_fs_drop_cnt", drop_cnt, 6);
    chk("full_fs_frame_cnt", frame_cnt, 3);
    drive(0, 0, 16'h0, 0, 1);
    tick;
    chk("clr_overflow", overflow, 0);
    chk("clr_drop_cnt", drop_cnt, 0);
    $display("fill: 16 queued, drops cleared");

    // Drain while in WAIT_FRAME: stray pixels must be neither queued nor counted.
    for (int k = 0; k < 16; k++) begin
      exp_w = (k == 0) ? 16'hA55A : 16'(k);
      chk($sformatf("drain%0d_valid", k), out_valid, 1);
      chk($sformatf("drain%0d_data", k), out_data, exp_w);
      drive(0, 1, 16'hBEEF, 1, 0);
      tick;
    end
    chk("drain_empty", out_valid, 0);
    chk("drain_drop_cnt", drop_cnt, 0);
    $display("drain: 16 words popped in order");

    // DROP persists even once space frees up.
    drive(1, 0, 16'h0, 0, 0);
    tick;
    for (int i = 0; i < 15; i++) begin
      drive(0, 1, 16'(16'h0100 + i), 0, 0);
      tick;
    end
    drive(0, 1, 16'h0200, 0, 0);
    tick;
    chk("dropst_drop_cnt", drop_cnt, 1);
    drive(0, 0, 16'h0, 1, 0);
    tick;
    chk("dropst_head_after_pop", out_data, 16'h0100);
    drive(0, 1, 16'h0300, 0, 0);
    tick;
    chk("dropst_still_dropping", drop_cnt, 2);
    drive(0, 1, 16'h0301, 0, 1);
    tick;
    chk("clr_vs_drop_overflow", overflow, 1);
    chk("clr_vs_drop_drop_cnt", drop_cnt, 1);
    drive(0, 0, 16'h0, 0, 1);
    tick;
    chk("clr2_drop_cnt", drop_cnt, 0);
    $display("drop state: drops continue with space, clr/drop collision gives 1");

    drive(0, 1, 16'h0400, 0, 0);
    for (int i = 0; i < 65540; i++) tick;
    chk("saturate_drop_cnt", drop_cnt, 16'hFFFF);
    chk("saturate_frame_cnt", frame_cnt, 4);
    $display("saturation: drop_cnt=%h", drop_cnt);

    // Asynchronous reset while words are queued.
    drive(0, 0, 16'h0, 0, 0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_out_valid", out_valid, 0);
    chk("async_rst_drop_cnt", drop_cnt, 0);
    chk("async_rst_overflow", overflow, 0);
    chk("async_rst_frame_cnt", frame_cnt, 0);
    tick;
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 16'h5555, 1, 0);
      tick;
      chk($sformatf("post_rst%0d_valid", i), out_valid, 0);
    end
    chk("post_rst_drop_cnt", drop_cnt, 0);
    $display("reset: queue discarded, idle until frame_start");

    for (int i = 0; i < 256; i++) begin
      drive(1, 0, 16'h0, 1, 0);
      tick;
      if (i == 254) chk("frame_cnt_ff", frame_cnt, 8'hFF);
    end
    chk("frame_cnt_wrap", frame_cnt, 8'h00);
    drive(0, 0, 16'h0, 1, 0);
    tick;
    chk("wrap_drained", out_valid, 0);
    $display("frame_cnt wrap: %h", frame_cnt);

    // Stall test: out_ready toggles each cycle across a 40-pixel frame.
    do_reset;
    drive(1, 0, 16'h0, 0, 0);
    exp_q.push_back(16'hA55A);
    tick;
    sent   = 0;
    popped = 0;
    cyc    = 0;
    while ((sent < 40 || exp_q.size() > 0) && cyc < 400) begin
      drive(0, (sent < 40) && (cyc < 10 || cyc % 2 == 0), 16'(16'hC000 + sent), cyc[0], 0);
      if (pix_valid) begin
        exp_q.push_back(pix_data);
        sent++;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("stall_unexpected_word", out_data, 32'hFFFF_FFFF);
        end else begin
          exp_w = exp_q.pop_front();
          chk($sformatf("stall_pop%0d", popped), out_data, exp_w);
        end
        popped++;
      end
      hold   = out_valid && !out_ready;
      hold_d = out_data;
      tick;
      if (hold) begin
        chk("stall_hold_valid", out_valid, 1);
        chk("stall_hold_data", out_data, hold_d);
      end
      cyc++;
    end
    chk("stall_cycle_budget", (cyc < 400) ? 1 : 0, 1);
    chk("stall_popped", popped, 41);
    chk("stall_drop_cnt", drop_cnt, 0);
    chk("stall_empty", out_valid, 0);
    $display("stall: %0d words popped over %0d cycles", popped, cyc);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
